fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 SHALL have parameter ADDR_W, default 5, instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_addr  output  ADDR_W  word address to instruction memory, equal to fetch PC bits [ADDR_W+1:2].
REQ-006 SHALL have port imem_rw  output  1  memory read/write select, constant 1 (read).
REQ-007 SHALL have port imem_wdata  output  32  memory write data, constant 0.
REQ-008 SHALL have port imem_rdata  input  32  read data, valid one cycle after imem_addr is sampled.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-010 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-011 SHALL have port ins_valid  output  1  instruction available to decode.
REQ-012 SHALL have port ins_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port ins_out  output  32  instruction word.
REQ-014 SHALL have port ins_pc  output  32  byte address of ins_out.
REQ-015 SHALL have ports perf_fetched and perf_stall  output  32 each  performance counters (see Configuration).

Function
REQ-016 SHALL keep a 32-bit fetch PC; each issued read increments it by 4, wrapping modulo 2^32; imem_addr wraps modulo 2^ADDR_W words.
REQ-017 SHALL hold issued-but-unreturned reads in a 1-bit inflight flag with associated PC, and returned words in a 2-entry FIFO (instruction + PC); ins_valid/ins_out/ins_pc SHALL reflect the FIFO head only.
REQ-018 SHALL write returning imem_rdata into the FIFO at the end of the cycle after issue, unless the read is cancelled.
REQ-019 SHALL issue a read in a cycle only when occupancy + inflight - pop <= 1, where pop = ins_valid & ins_ready; otherwise imem_addr SHALL hold and no issue occurs.
REQ-020 SHALL complete a transfer on any cycle with ins_valid & ins_ready; ins_out/ins_pc SHALL remain stable while ins_valid=1 and ins_ready=0.
REQ-021 SHALL sustain one instruction per cycle while ins_ready is held at 1.
REQ-022 On redirect_valid=1, SHALL drive imem_addr from redirect_pc[ADDR_W+1:2] in that same cycle, issue it, set fetch PC to {redirect_pc[31:2],2'b00}+4, flush the FIFO and cancel any inflight read.
REQ-023 SHALL ignore redirect_pc[1:0]; the issued PC and the resulting ins_pc SHALL have bits [1:0]=00.
REQ-024 Redirect in cycle N SHALL yield ins_valid=1 in cycle N+2 with ins_pc equal to the aligned redirect_pc.
REQ-025 If redirect_valid and a handshake occur in the same cycle, SHALL count the handshake as complete, then flush.
REQ-026 SHALL implement FSM BOOT->RUN: BOOT is the first cycle after reset release, which issues RESET_PC; RUN thereafter; reset returns the FSM to BOOT.
REQ-027 SHALL report first instruction ins_valid=1 in cycle 2 after reset release (BOOT = cycle 0).

Reset
REQ-028 While rst=1: ins_valid=0, ins_out=0, ins_pc=0, FIFO empty, inflight=0, fetch PC=RESET_PC, imem_addr=RESET_PC[ADDR_W+1:2], counters=0.
REQ-029 Reset asserted mid-operation SHALL clear all state immediately, without waiting for clk; data returning after release for a pre-reset read SHALL be discarded.

Configuration
REQ-030 With macro FETCH_PERF_CNT_EN defined, perf_fetched SHALL count completed handshakes and perf_stall SHALL count cycles with ins_valid=1 and ins_ready=0, both wrapping modulo 2^32.
REQ-031 Without FETCH_PERF_CNT_EN, both counter outputs SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-032 Release reset with RESET_PC=0, ins_ready=1, memory words 0..3 = A,B,C,D -> ins_out A,B,C,D in cycles 2..5 with ins_pc 0,4,8,C.
REQ-033 Drop ins_ready to 0 in cycle 3 for 4 cycles -> ins_out holds B, no loss or duplication; C,D follow after release; perf_stall=4 with FETCH_PERF_CNT_EN.
REQ-034 Redirect to 32'h0000_0032 in cycle 4 -> next ins_valid in cycle 6 with ins_pc 32'h30, instruction word 12; no stale word delivered.
REQ-035 Fetch through PC 32'h7C -> imem_addr wraps from 31 to 0 and ins_pc continues 32'h80.
REQ-036 Assert rst mid-stream for 1 cycle with ins_valid=1 -> ins_valid drops same cycle; restarts at RESET_PC, first valid in cycle 2 after release.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory port, redirect strobe and
// decode-side valid/ready handshake. master = fetch unit, slave = environment.
interface fetch_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rw;
  logic [31:0]       imem_wdata;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              ins_valid;
  logic              ins_ready;
  logic [31:0]       ins_out;
  logic [31:0]       ins_pc;

  modport master (
    output imem_addr, imem_rw, imem_wdata,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output ins_valid, ins_out, ins_pc,
    input  ins_ready
  );

  modport slave (
    input  imem_addr, imem_rw, imem_wdata,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  ins_valid, ins_out, ins_pc,
    output ins_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one read in flight feeding a 2-entry instruction/PC FIFO,
// with same-cycle redirect. Optional performance counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);
  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic        vld_p0;
  logic [31:0] pc_p0;
  logic [31:0] ins_p1 [2];
  logic [31:0] pc_p1  [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        redirect;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  demand;
  logic [31:0] issue_pc;
  logic        unused_lsb;

  // Reset must win over a concurrent redirect so imem_addr shows RESET_PC.
  assign redirect   = bus.redirect_valid & ~rst;
  assign issue_pc   = redirect ? {bus.redirect_pc[31:2], 2'b00} : pc;
  assign unused_lsb = ^bus.redirect_pc[1:0];

  assign pop    = bus.ins_valid & bus.ins_ready;
  assign demand = {1'b0, count} + {2'b00, vld_p0} - {2'b00, pop};
  assign issue  = ~rst & (redirect | (state == ST_BOOT) | (demand <= 3'd1));
  // A redirect cancels the word returning this cycle.
  assign push   = vld_p0 & ~redirect;

  assign bus.imem_addr  = issue_pc[ADDR_W+1:2];
  assign bus.imem_rw    = 1'b1;
  assign bus.imem_wdata = 32'h0000_0000;

  assign bus.ins_valid = (count != 2'd0);
  assign bus.ins_out   = bus.ins_valid ? ins_p1[rd_ptr] : 32'h0000_0000;
  assign bus.ins_pc    = bus.ins_valid ? pc_p1[rd_ptr]  : 32'h0000_0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_BOOT;
      pc     <= RESET_PC;
      vld_p0 <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      state  <= ST_RUN;
      vld_p0 <= issue;
      if (issue)
        pc <= issue_pc + 32'd4;
      if (redirect) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push)
          wr_ptr <= ~wr_ptr;
        if (pop)
          rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // ---- stage p0 (read in flight) -> stage p1 (instruction FIFO) ----
  always_ff @(posedge clk) begin
    if (issue)
      pc_p0 <= issue_pc;
    if (push) begin
      ins_p1[wr_ptr] <= bus.imem_rdata;
      pc_p1[wr_ptr]  <= pc_p0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_cnt <= 32'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (pop)
        fetched_cnt <= fetched_cnt + 32'd1;
      if (bus.ins_valid & ~bus.ins_ready)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_fetched = fetched_cnt;
  assign perf_stall   = stall_cnt;
`else
  assign perf_fetched = 32'd0;
  assign perf_stall   = 32'd0;
`endif

endmodule
